// File: rtl/adc_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_fifo_pkg : shared constants and types for the ADC sample FIFO control  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package adc_fifo_pkg;

  localparam int ADC_DWIDTH = 16;
  localparam int ADC_AWIDTH = 10;
  localparam int ADC_DEPTH  = 1 << ADC_AWIDTH;

  typedef logic [ADC_DWIDTH-1:0] sample_t;

  // Occupancy of the head + skid output stage
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage
`default_nettype wire

// File: rtl/adc_fifo_outstage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_fifo_outstage : head + skid registers presenting a FWFT head word      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adc_fifo_outstage
  import adc_fifo_pkg::*;
#(
  parameter int DWIDTH = ADC_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_q,
  output logic              o_empty,
  output logic [1:0]        o_occ
);

  occ_e              occ_q, occ_d;
  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              empty_q, empty_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (i_fill) begin
          head_d = i_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({i_pop, i_fill})
          2'b11:   head_d = i_data;
          2'b10:   occ_d  = OCC_EMPTY;
          2'b01: begin
            skid_d = i_data;
            occ_d  = OCC_TWO;
          end
          default: occ_d  = OCC_ONE;
        endcase
      end
      OCC_TWO: begin
        // Returning RAM word only lands here when the same-cycle pop frees a slot
        if (i_pop) begin
          head_d = skid_q;
          if (i_fill) skid_d = i_data;
          else        occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    empty_d = (occ_d == OCC_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      empty_q <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      empty_q <= empty_d;
    end
  end

  assign o_q     = head_q;
  assign o_empty = empty_q;
  assign o_occ   = occ_q;

endmodule
`default_nettype wire

// File: rtl/adc_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_fifo_ctrl : pointer/flag controller for the 1Kx16 ADC sample LSRAM,    |
// | FWFT read side. ADC_FIFO_OVF_STATS_EN enables OVF / DROP_CNT statistics.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adc_fifo_ctrl
  import adc_fifo_pkg::*;
#(
  parameter int DWIDTH       = ADC_DWIDTH,
  parameter int AWIDTH       = ADC_AWIDTH,
  parameter int AFULL_THRESH = 1008
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [DWIDTH-1:0] DATA_IN,
  output logic              FULL,
  output logic              AFULL,
  input  logic              RE,
  output logic [DWIDTH-1:0] Q,
  output logic              EMPTY,
  output logic [AWIDTH+1:0] COUNT,
  output logic              OVF,
  output logic [15:0]       DROP_CNT,
  output logic [DWIDTH-1:0] RAM_WD,
  output logic [AWIDTH-1:0] RAM_WADDR,
  output logic              RAM_WEN,
  output logic [AWIDTH-1:0] RAM_RADDR,
  output logic              RAM_REN,
  input  logic [DWIDTH-1:0] RAM_RD
);

  localparam int              CW        = AWIDTH + 2;
  localparam int              DEPTH     = 1 << AWIDTH;
  localparam logic [AWIDTH:0] RAM_FULL  = (AWIDTH+1)'(DEPTH);
  localparam logic [CW-1:0]   AFULL_LVL = CW'(AFULL_THRESH);

  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;

  logic              w_ram_wen;
  logic              w_ram_ren;
  logic              w_pop;
  logic              w_empty;
  logic [1:0]        w_occ;
  logic [2:0]        w_occ_after;

  assign w_ram_wen   = WE & ~full_q;
  assign w_pop       = RE & ~w_empty;
  // Output-stage slots already committed once this cycle's pop and return settle
  assign w_occ_after = {1'b0, w_occ} + {2'b00, rd_pend_q} - {2'b00, w_pop};
  assign w_ram_ren   = (ram_cnt_q != '0) && (w_occ_after < 3'd2);

  always_comb begin
    wptr_d    = w_ram_wen ? wptr_q + AWIDTH'(1) : wptr_q;
    rptr_d    = w_ram_ren ? rptr_q + AWIDTH'(1) : rptr_q;
    ram_cnt_d = ram_cnt_q + (AWIDTH+1)'(w_ram_wen) - (AWIDTH+1)'(w_ram_ren);
    rd_pend_d = w_ram_ren;
    count_d   = count_q + CW'(w_ram_wen) - CW'(w_pop);
    full_d    = (ram_cnt_d == RAM_FULL);
    afull_d   = (count_d >= AFULL_LVL);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      count_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
    end
  end

  adc_fifo_outstage #(
    .DWIDTH (DWIDTH)
  ) u_outstage (
    .clk     (CLK),
    .rst     (RESET),
    .i_fill  (rd_pend_q),
    .i_data  (RAM_RD),
    .i_pop   (w_pop),
    .o_q     (Q),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

`ifdef ADC_FIFO_OVF_STATS_EN
  logic        ovf_q, ovf_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        w_drop;

  assign w_drop = WE & full_q;

  always_comb begin
    ovf_d      = ovf_q | w_drop;
    drop_cnt_d = (w_drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign OVF      = ovf_q;
  assign DROP_CNT = drop_cnt_q;
`else
  assign OVF      = 1'b0;
  assign DROP_CNT = 16'h0000;
`endif

  assign EMPTY     = w_empty;
  assign FULL      = full_q;
  assign AFULL     = afull_q;
  assign COUNT     = count_q;
  assign RAM_WD    = DATA_IN;
  assign RAM_WADDR = wptr_q;
  assign RAM_WEN   = w_ram_wen;
  assign RAM_RADDR = rptr_q;
  assign RAM_REN   = w_ram_ren;

endmodule
`default_nettype wire

// File: tb/tb_adc_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adc_fifo_ctrl : scoreboard bench for adc_fifo_ctrl with a 1-cycle RAM   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_adc_fifo_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int CAP   = DEPTH + 2;
  localparam int AFT   = 1008;

  logic          CLK = 1'b0;
  logic          RESET, WE, RE;
  logic [DW-1:0] DATA_IN, Q, RAM_WD, RAM_RD;
  logic          FULL, AFULL, EMPTY, OVF, RAM_WEN, RAM_REN;
  logic [AW+1:0] COUNT;
  logic [15:0]   DROP_CNT;
  logic [AW-1:0] RAM_WADDR, RAM_RADDR;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0, n_fail = 0;
  int            m_cnt = 0, m_wptr = 0, m_drops = 0;
  logic          m_ovf = 1'b0;

  always #5 CLK = ~CLK;

  adc_fifo_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .WE        (WE),
    .DATA_IN   (DATA_IN),
    .FULL      (FULL),
    .AFULL     (AFULL),
    .RE        (RE),
    .Q         (Q),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVF       (OVF),
    .DROP_CNT  (DROP_CNT),
    .RAM_WD    (RAM_WD),
    .RAM_WADDR (RAM_WADDR),
    .RAM_WEN   (RAM_WEN),
    .RAM_RADDR (RAM_RADDR),
    .RAM_REN   (RAM_REN),
    .RAM_RD    (RAM_RD)
  );

  always @(posedge CLK) begin
    if (RAM_WEN) mem[RAM_WADDR] <= RAM_WD;
    if (RAM_REN) RAM_RD <= mem[RAM_RADDR];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, settle, score pops, then check registered state
  task automatic step(input logic we, input logic [DW-1:0] din, input logic re);
    logic acc, pop;
    WE = we; DATA_IN = din; RE = re;
    #1;
    acc = we && (m_cnt < CAP);
    pop = re && !EMPTY;
    check_eq("ram_wen", RAM_WEN, acc);
    if (exp_q.size() == 0) check_eq("empty_vs_sb", EMPTY, 1'b1);
    if (pop && exp_q.size() > 0) check_eq("q_data", Q, exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(din);
      m_wptr = (m_wptr + 1) % DEPTH;
    end
    if (we && !acc) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    if (acc && !pop) m_cnt++;
    else if (!acc && pop) m_cnt--;
    @(negedge CLK);
    check_eq("count", COUNT, m_cnt);
    check_eq("afull", AFULL, m_cnt >= AFT);
    check_eq("waddr", RAM_WADDR, m_wptr);
`ifdef ADC_FIFO_OVF_STATS_EN
    check_eq("ovf", OVF, m_ovf);
    check_eq("drop_cnt", DROP_CNT, m_drops);
`else
    check_eq("ovf", OVF, 1'b0);
    check_eq("drop_cnt", DROP_CNT, 0);
`endif
  endtask

  task automatic drain();
    int budget = 4000;
    while (exp_q.size() > 0 && budget > 0) begin
      step(1'b0, '0, 1'b1);
      budget--;
    end
    if (exp_q.size() > 0) check_eq("drain_timeout", exp_q.size(), 0);
    repeat (3) step(1'b0, '0, 1'b0);
    check_eq("empty_after_drain", EMPTY, 1'b1);
    check_eq("count_after_drain", COUNT, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1; WE = 1'b0; RE = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.delete();
    m_cnt = 0; m_wptr = 0; m_drops = 0; m_ovf = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] seq;
    RESET = 1'b1; WE = 1'b0; RE = 1'b0; DATA_IN = '0;
    repeat (3) @(negedge CLK);
    do_reset();

    check_eq("rst_empty", EMPTY, 1'b1);
    check_eq("rst_full", FULL, 1'b0);
    check_eq("rst_afull", AFULL, 1'b0);
    check_eq("rst_count", COUNT, 0);
    check_eq("rst_q", Q, 0);
    check_eq("rst_ovf", OVF, 1'b0);
    check_eq("rst_drop", DROP_CNT, 0);
    check_eq("rst_ren", RAM_REN, 1'b0);

    // Single word latency: EMPTY falls two cycles after the push
    step(1'b1, 16'hA5A5, 1'b0);
    check_eq("lat_c0_empty", EMPTY, 1'b1);
    step(1'b0, '0, 1'b0);
    check_eq("lat_c1_empty", EMPTY, 1'b1);
    step(1'b0, '0, 1'b0);
    check_eq("lat_c2_empty", EMPTY, 1'b0);
    check_eq("lat_q", Q, 16'hA5A5);
    step(1'b0, '0, 1'b1);
    check_eq("pop_empty", EMPTY, 1'b1);

    // Fill to capacity, then push while full
    for (int i = 0; i < CAP; i++) begin
      step(1'b1, DW'(i), 1'b0);
      check_eq("full_fill", FULL, m_cnt == CAP);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(2000 + i), 1'b0);
      check_eq("full_hold", FULL, 1'b1);
    end
    drain();

    // Continuous push+pop with the pointers wrapping several times
    seq = 16'h1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq, 1'b0);
      seq++;
    end
    repeat (4) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, seq, 1'b1);
      seq++;
    end
    check_eq("steady_count", COUNT, 4);
    drain();

    // Continuous writes against a reader with random gaps
    for (int i = 0; i < 600; i++) begin
      d = DW'($urandom);
      step(1'b1, d, ($urandom_range(0, 2) != 0));
    end
    drain();

    // Reset with data held discards everything
    for (int i = 0; i < 500; i++) step(1'b1, DW'(16'h4000 + i), 1'b0);
    check_eq("pre_rst_count", COUNT, 500);
    do_reset();
    check_eq("mid_rst_empty", EMPTY, 1'b1);
    check_eq("mid_rst_count", COUNT, 0);
    check_eq("mid_rst_ovf", OVF, 1'b0);
    check_eq("mid_rst_full", FULL, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'hCAFE, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
